// File: rtl/sram_loader.sv
// Byte-stream SRAM loader: A5, count, data words, optional checksum.
// Define SRAM_LOADER_CHECKSUM_EN to add the trailing XOR checksum byte.
module sram_loader #(
    parameter int          SRAM_ADDRESS_WIDTH = 18,
    parameter int          SRAM_DATA_WIDTH    = 16,
    parameter logic [7:0]  CMD_LOAD           = 8'hA5
) (
    input  logic                          wb_clk_i,
    input  logic                          wb_rst_n_i,
    input  logic [7:0]                    rx_dat_i,
    input  logic                          rx_stb_i,
    output logic                          rx_ack_o,
    output logic                          sram_wb_cyc_o,
    output logic                          sram_wb_stb_o,
    output logic                          sram_wb_we_o,
    output logic [SRAM_ADDRESS_WIDTH-1:0] sram_wb_adr_o,
    output logic [SRAM_DATA_WIDTH-1:0]    sram_wb_dat_o,
    input  logic                          sram_wb_ack_i,
    output logic                          run_stb_o,
    output logic                          busy_o,
    output logic                          err_o
);

`ifdef SRAM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        IDLE, CNT_HI, CNT_LO, DAT_HI, DAT_LO, WRITE, CHECK, DONE
    } state_t;
    localparam state_t TAIL = CHECK;
`else
    typedef enum logic [2:0] {
        IDLE, CNT_HI, CNT_LO, DAT_HI, DAT_LO, WRITE, DONE
    } state_t;
    localparam state_t TAIL = DONE;
`endif

    state_t                        state_q, state_d;
    logic                          rx_ack_q;
    logic                          accept;
    logic [15:0]                   cnt_q;
    logic [SRAM_ADDRESS_WIDTH-1:0] adr_q;
    logic [SRAM_DATA_WIDTH-1:0]    dat_q;
    logic [7:0]                    hi_q;
    logic                          nz_q;
    logic                          err_q;
`ifdef SRAM_LOADER_CHECKSUM_EN
    logic [7:0]                    csum_q;
`endif

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        unique case (state_q)
            IDLE: begin
                accept = 1'b1;
                if (rx_ack_q && rx_dat_i == CMD_LOAD)
                    state_d = CNT_HI;
            end
            CNT_HI: begin
                accept = 1'b1;
                if (rx_ack_q) state_d = CNT_LO;
            end
            CNT_LO: begin
                accept = 1'b1;
                if (rx_ack_q)
                    state_d = ({cnt_q[15:8], rx_dat_i} != 16'd0)
                            ? DAT_HI : TAIL;
            end
            DAT_HI: begin
                accept = 1'b1;
                if (rx_ack_q) state_d = DAT_LO;
            end
            DAT_LO: begin
                accept = 1'b1;
                if (rx_ack_q) state_d = WRITE;
            end
            WRITE: begin
                if (sram_wb_ack_i)
                    state_d = (cnt_q == 16'd1) ? TAIL : DAT_HI;
            end
`ifdef SRAM_LOADER_CHECKSUM_EN
            CHECK: begin
                accept = 1'b1;
                if (rx_ack_q) state_d = DONE;
            end
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q  <= IDLE;
            rx_ack_q <= 1'b0;
            cnt_q    <= '0;
            adr_q    <= '0;
            dat_q    <= '0;
            hi_q     <= '0;
            nz_q     <= 1'b0;
            err_q    <= 1'b0;
`ifdef SRAM_LOADER_CHECKSUM_EN
            csum_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            // Registered pulse; a consumed byte is never re-acked next cycle
            rx_ack_q <= rx_stb_i && !rx_ack_q && accept;
            if (rx_ack_q) begin
                case (state_q)
                    IDLE: if (rx_dat_i == CMD_LOAD) begin
                        adr_q  <= '0;
                        err_q  <= 1'b0;
`ifdef SRAM_LOADER_CHECKSUM_EN
                        csum_q <= '0;
`endif
                    end
                    CNT_HI: begin
                        cnt_q[15:8] <= rx_dat_i;
`ifdef SRAM_LOADER_CHECKSUM_EN
                        csum_q <= csum_q ^ rx_dat_i;
`endif
                    end
                    CNT_LO: begin
                        cnt_q[7:0] <= rx_dat_i;
                        nz_q <= {cnt_q[15:8], rx_dat_i} != 16'd0;
`ifdef SRAM_LOADER_CHECKSUM_EN
                        csum_q <= csum_q ^ rx_dat_i;
`endif
                    end
                    DAT_HI: begin
                        hi_q <= rx_dat_i;
`ifdef SRAM_LOADER_CHECKSUM_EN
                        csum_q <= csum_q ^ rx_dat_i;
`endif
                    end
                    DAT_LO: begin
                        dat_q <= SRAM_DATA_WIDTH'({hi_q, rx_dat_i});
`ifdef SRAM_LOADER_CHECKSUM_EN
                        csum_q <= csum_q ^ rx_dat_i;
`endif
                    end
`ifdef SRAM_LOADER_CHECKSUM_EN
                    CHECK: if (rx_dat_i != csum_q) err_q <= 1'b1;
`endif
                    default: ;
                endcase
            end
            if (state_q == WRITE && sram_wb_ack_i) begin
                adr_q <= adr_q + SRAM_ADDRESS_WIDTH'(1);
                cnt_q <= cnt_q - 16'd1;
            end
        end
    end

    assign rx_ack_o      = rx_ack_q;
    assign sram_wb_cyc_o = (state_q == WRITE);
    assign sram_wb_stb_o = (state_q == WRITE);
    assign sram_wb_we_o  = (state_q == WRITE);
    assign sram_wb_adr_o = adr_q;
    assign sram_wb_dat_o = dat_q;
    assign busy_o        = (state_q != IDLE);
    assign run_stb_o     = (state_q == DONE) && nz_q && !err_q;
`ifdef SRAM_LOADER_CHECKSUM_EN
    assign err_o         = err_q;
`else
    assign err_o         = 1'b0;
`endif

endmodule
